// File: rtl/fifo_rd_frame.sv
// rtl/fifo_rd_frame.sv - ADC sample FIFO read-side frame controller with per-frame statistics
module fifo_rd_frame #(
  parameter int FRAME_LEN = 256,
  parameter int TIMEOUT   = 1023
) (
  input  logic        rd_clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        rd_rst_busy,
  input  logic        empty,
  input  logic [7:0]  fifo_rd_data,
  output logic        fifo_rd_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic [8:0]  sample_idx,
  output logic [7:0]  frame_min,
  output logic [7:0]  frame_max,
  output logic [15:0] frame_sum,
  output logic        stats_valid,
  output logic        underrun_error,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam logic [8:0] LAST_IDX = 9'(FRAME_LEN - 1);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_LATCH,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state;
  logic [8:0]  idx;
  logic [7:0]  run_min;
  logic [7:0]  run_max;
  logic [15:0] run_sum;
  logic [9:0]  tmo_cnt;
  logic        xfer;

  assign xfer = out_valid && out_ready;
  assign busy = (state != S_IDLE);

  // Frame FSM: one FIFO read per sample, hold the sample until the consumer takes it
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= 9'd0;
      run_min        <= 8'hFF;
      run_max        <= 8'h00;
      run_sum        <= 16'd0;
      tmo_cnt        <= 10'd0;
      fifo_rd_en     <= 1'b0;
      out_data       <= 8'h00;
      out_valid      <= 1'b0;
      out_sof        <= 1'b0;
      out_eof        <= 1'b0;
      sample_idx     <= 9'd0;
      frame_min      <= 8'h00;
      frame_max      <= 8'h00;
      frame_sum      <= 16'd0;
      stats_valid    <= 1'b0;
      underrun_error <= 1'b0;
      frame_cnt      <= 16'd0;
    end else if (rd_rst_busy) begin
      // FIFO is resetting: abandon the frame but keep the last frame's results
      state       <= S_IDLE;
      fifo_rd_en  <= 1'b0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      stats_valid <= 1'b0;
    end else begin
      fifo_rd_en  <= 1'b0;
      stats_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state          <= S_WAIT;
            idx            <= 9'd0;
            run_sum        <= 16'd0;
            run_min        <= 8'hFF;
            run_max        <= 8'h00;
            underrun_error <= 1'b0;
            tmo_cnt        <= 10'd0;
          end
        end
        S_WAIT: begin
          if (!empty) begin
            state      <= S_READ;
            fifo_rd_en <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            underrun_error <= 1'b1;
            state          <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        S_READ: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          // fifo_rd_data is valid this cycle (one cycle after the read strobe)
          out_data   <= fifo_rd_data;
          if (fifo_rd_data < run_min) run_min <= fifo_rd_data;
          if (fifo_rd_data > run_max) run_max <= fifo_rd_data;
          run_sum    <= run_sum + {8'h00, fifo_rd_data};
          out_valid  <= 1'b1;
          out_sof    <= (idx == 9'd0);
          out_eof    <= (idx == LAST_IDX);
          sample_idx <= idx;
          state      <= S_HOLD;
        end
        S_HOLD: begin
          if (xfer) begin
            out_valid <= 1'b0;
            idx       <= idx + 9'd1;
            if (idx == LAST_IDX) begin
              state <= S_DONE;
            end else if (!empty) begin
              state      <= S_READ;
              fifo_rd_en <= 1'b1;
            end else begin
              state   <= S_WAIT;
              tmo_cnt <= 10'd0;
            end
          end
        end
        S_DONE: begin
          frame_min   <= run_min;
          frame_max   <= run_max;
          frame_sum   <= run_sum;
          stats_valid <= 1'b1;
          frame_cnt   <= frame_cnt + 16'd1;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_frame.sv
// tb/tb_fifo_rd_frame.sv - directed scoreboard bench for fifo_rd_frame
module tb_fifo_rd_frame;

  localparam int FRAME_LEN = 256;
  localparam int TMO       = 20;

  logic        rd_clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        rd_rst_busy;
  logic        empty;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eof;
  logic [8:0]  sample_idx;
  logic [7:0]  frame_min;
  logic [7:0]  frame_max;
  logic [15:0] frame_sum;
  logic        stats_valid;
  logic        underrun_error;
  logic [15:0] frame_cnt;
  logic        busy;

  fifo_rd_frame #(.FRAME_LEN(FRAME_LEN), .TIMEOUT(TMO)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .frame_start(frame_start), .rd_rst_busy(rd_rst_busy),
    .empty(empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .sample_idx(sample_idx),
    .frame_min(frame_min), .frame_max(frame_max), .frame_sum(frame_sum),
    .stats_valid(stats_valid), .underrun_error(underrun_error),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  // Standard-mode FIFO model: data appears the cycle after the read strobe
  logic [7:0] fmem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       flush_req = 1'b0;

  assign empty = (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    if (flush_req) rd_ptr <= wr_ptr;
    else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rd_data <= fmem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Monitor: records transfers and protocol observations mid-cycle
  logic [18:0] cur_word;
  logic [71:0] all_outs;
  assign cur_word = {out_data, out_sof, out_eof, sample_idx};
  assign all_outs = {fifo_rd_en, out_data, out_valid, out_sof, out_eof, sample_idx, frame_min,
                     frame_max, frame_sum, stats_valid, underrun_error, frame_cnt, busy};

  logic [18:0] ob_word [0:4095];
  int          ob_cyc  [0:4095];
  int          ob_n = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          rd_bad = 0;
  int          stab_bad = 0;
  int          stats_cnt = 0;
  int          un_cyc = 0;
  logic        p_stall = 1'b0;
  logic        p_abort = 1'b0;
  logic        p_un = 1'b0;
  logic [18:0] p_word = '0;

  always @(negedge rd_clk) begin
    cyc = cyc + 1;
    if (fifo_rd_en) begin
      rd_cnt = rd_cnt + 1;
      if (empty) rd_bad = rd_bad + 1;
    end
    if (p_stall && !p_abort && !(out_valid && (cur_word == p_word))) stab_bad = stab_bad + 1;
    if (out_valid && out_ready) begin
      ob_word[ob_n] = cur_word;
      ob_cyc[ob_n]  = cyc;
      ob_n = ob_n + 1;
    end
    if (stats_valid) stats_cnt = stats_cnt + 1;
    if (underrun_error && !p_un) un_cyc = cyc;
    p_un    = underrun_error;
    p_stall = out_valid && !out_ready;
    p_abort = rd_rst_busy || !rst_n;
    p_word  = cur_word;
  end

  int          errors = 0;
  int          checks = 0;
  logic [18:0] exp_q [$];
  int          ob_rd = 0;
  int          r0, s0;
  int          e_min, e_max, e_sum;
  logic [7:0]  v;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push_fifo(input logic [7:0] d);
    fmem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic push_exp(input logic [7:0] d, input int i);
    exp_q.push_back({d, (i == 0), (i == FRAME_LEN - 1), 9'(i)});
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic run_idle(input int budget, input bit bp, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (bp) out_ready = ((k % 4) == 0);
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    tick();
    chk(tag, 80'(ok), 80'(1));
  endtask

  task automatic wait_idx(input int n, input int budget, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (out_valid && (sample_idx == 9'(n))) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 80'(ok), 80'(1));
  endtask

  task automatic drain(input string tag, input bit gap);
    logic [18:0] e;
    while (ob_rd < ob_n) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_extra"}, 80'(ob_n - ob_rd), 80'(0));
        ob_rd = ob_n;
        break;
      end
      e = exp_q.pop_front();
      chk(tag, 80'(ob_word[ob_rd]), 80'(e));
      if (gap && (ob_word[ob_rd][8:0] != 9'd0))
        chk({tag, "_gap"}, 80'(ob_cyc[ob_rd] - ob_cyc[ob_rd-1]), 80'(3));
      ob_rd++;
    end
    chk({tag, "_missing"}, 80'(exp_q.size()), 80'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; rd_rst_busy = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("reset_outs", 80'(all_outs), 80'(0));
    rst_n = 1'b1; out_ready = 1'b1;
    tick();

    // Nominal ramp frame at full rate
    for (int i = 0; i < 256; i++) begin
      push_fifo(8'(i));
      push_exp(8'(i), i);
    end
    r0 = rd_cnt; s0 = stats_cnt;
    start_frame();
    run_idle(2000, 1'b0, "nom_done");
    drain("nom", 1'b1);
    chk("nom_reads", 80'(rd_cnt - r0), 80'(256));
    chk("nom_stats_pulses", 80'(stats_cnt - s0), 80'(1));
    chk("nom_min_max_sum", 80'({frame_min, frame_max, frame_sum}), 80'({8'h00, 8'hFF, 16'd32640}));
    chk("nom_frame_cnt", 80'(frame_cnt), 80'(1));
    chk("nom_busy_ur", 80'({busy, underrun_error}), 80'(0));

    // Backpressure: ready 1-on/3-off on a constant frame
    for (int i = 0; i < 256; i++) begin
      push_fifo(8'hA5);
      push_exp(8'hA5, i);
    end
    r0 = rd_cnt; s0 = stats_cnt;
    start_frame();
    run_idle(4000, 1'b1, "bp_done");
    drain("bp", 1'b0);
    chk("bp_reads", 80'(rd_cnt - r0), 80'(256));
    chk("bp_stable", 80'(stab_bad), 80'(0));
    chk("bp_stats_pulses", 80'(stats_cnt - s0), 80'(1));
    chk("bp_min_max_sum", 80'({frame_min, frame_max, frame_sum}), 80'({8'hA5, 8'hA5, 16'hA500}));
    chk("bp_frame_cnt", 80'(frame_cnt), 80'(2));

    // Underrun: only 10 samples available
    for (int i = 0; i < 10; i++) begin
      v = 8'(i * 13 + 7);
      push_fifo(v);
      push_exp(v, i);
    end
    r0 = rd_cnt; s0 = stats_cnt;
    start_frame();
    run_idle(1000, 1'b0, "ur_done");
    drain("ur", 1'b1);
    chk("ur_reads", 80'(rd_cnt - r0), 80'(10));
    // WAIT entered on the edge after the last transfer's negedge; flag visible one negedge after 20th WAIT edge
    chk("ur_latency", 80'(un_cyc - ob_cyc[ob_n-1]), 80'(TMO + 1));
    chk("ur_flag_idle", 80'({underrun_error, busy}), 80'(2'b10));
    chk("ur_no_stats", 80'(stats_cnt - s0), 80'(0));
    chk("ur_frame_cnt", 80'(frame_cnt), 80'(2));

    // rd_rst_busy during sample 100, with a simultaneous frame_start
    for (int i = 0; i < 256; i++) begin
      push_fifo(8'(255 - i));
      if (i < 100) push_exp(8'(255 - i), i);
    end
    r0 = rd_cnt; s0 = stats_cnt;
    start_frame();
    chk("ur_cleared", 80'(underrun_error), 80'(0));
    wait_idx(100, 1000, "rb_reach");
    out_ready = 1'b0; rd_rst_busy = 1'b1; frame_start = 1'b1;
    tick();
    chk("rb_idle", 80'({busy, out_valid, out_sof, out_eof}), 80'(0));
    chk("rb_stats_kept", 80'({frame_min, frame_max, frame_sum, frame_cnt}),
        80'({8'hA5, 8'hA5, 16'hA500, 16'd2}));
    tick();
    chk("rb_start_ignored", 80'(busy), 80'(0));
    frame_start = 1'b0; rd_rst_busy = 1'b0; out_ready = 1'b1;
    tick();
    chk("rb_still_idle", 80'({busy, underrun_error}), 80'(0));
    chk("rb_no_stats", 80'(stats_cnt - s0), 80'(0));
    chk("rb_reads", 80'(rd_cnt - r0), 80'(101));
    flush();
    drain("rb", 1'b1);

    // frame_start repeated at idx 50 is ignored
    e_min = 255; e_max = 0; e_sum = 0;
    for (int i = 0; i < 256; i++) begin
      v = 8'((i * i + 3 * i + 40) % 251);
      push_fifo(v);
      push_exp(v, i);
      if (int'(v) < e_min) e_min = int'(v);
      if (int'(v) > e_max) e_max = int'(v);
      e_sum += int'(v);
    end
    r0 = rd_cnt; s0 = stats_cnt;
    start_frame();
    wait_idx(50, 1000, "ms_reach");
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_idle(2000, 1'b0, "ms_done");
    drain("ms", 1'b1);
    chk("ms_reads", 80'(rd_cnt - r0), 80'(256));
    chk("ms_stats_pulses", 80'(stats_cnt - s0), 80'(1));
    chk("ms_min_max_sum", 80'({frame_min, frame_max, frame_sum}),
        80'({8'(e_min), 8'(e_max), 16'(e_sum)}));
    chk("ms_frame_cnt", 80'(frame_cnt), 80'(3));

    // Reset pulse at idx 128
    for (int i = 0; i < 256; i++) begin
      push_fifo(8'(i) ^ 8'h5A);
      if (i < 128) push_exp(8'(i) ^ 8'h5A, i);
    end
    start_frame();
    wait_idx(128, 1000, "rst_reach");
    out_ready = 1'b0; rst_n = 1'b0;
    tick();
    chk("rst_outs", 80'(all_outs), 80'(0));
    rst_n = 1'b1; out_ready = 1'b1;
    r0 = rd_cnt;
    repeat (10) tick();
    chk("rst_no_reads", 80'(rd_cnt - r0), 80'(0));
    chk("rst_idle", 80'(busy), 80'(0));
    flush();
    drain("rst", 1'b1);

    chk("rd_en_while_empty", 80'(rd_bad), 80'(0));
    chk("hold_stable_all", 80'(stab_bad), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_frame.md
Name: fifo_rd_frame

Overview:
- Read-side controller on the downstream side of the ADC sample FIFO, in the rd_clk domain.
- Once armed by a frame-start pulse, drains exactly FRAME_LEN samples from the FIFO, one at a time.
- Presents each sample on a valid/ready stream with start-of-frame and end-of-frame markers.
- Accumulates per-frame min/max/sum statistics and flags FIFO underrun through a timeout.

Parameters:
- FRAME_LEN, 256, samples per frame; legal range 2..256.
- TIMEOUT, 1023, consecutive empty cycles in WAIT before declaring underrun; legal range 1..1023.

Ports:
- rd_clk  in  1  read clock; only clock.
- rst_n  in  1  synchronous active-low reset.
- frame_start  in  1  one-cycle arm pulse, already synchronous to rd_clk.
- rd_rst_busy  in  1  FIFO read-side reset busy.
- empty  in  1  FIFO empty.
- fifo_rd_data  in  8  FIFO read data; standard mode, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read enable; registered.
- out_data  out  8  sample to consumer.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_sof  out  1  qualifies the first sample of a frame.
- out_eof  out  1  qualifies the last sample of a frame.
- sample_idx  out  9  index of the sample currently on out_data.
- frame_min  out  8  minimum of the last completed frame.
- frame_max  out  8  maximum of the last completed frame.
- frame_sum  out  16  sum of the last completed frame.
- stats_valid  out  1  one-cycle pulse when a frame completes.
- underrun_error  out  1  sticky underrun flag; cleared by the next accepted frame_start.
- frame_cnt  out  16  completed-frame counter; wraps.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, rd_clk. Reset rst_n is synchronous and active-low.
- Reset values: all outputs 0, except the internal running min, which resets to 8'hFF. FSM resets to IDLE.
- Transfer rule: a transfer occurs on any rising edge where out_valid && out_ready.
- out_valid handshake: once raised, out_valid stays high and out_data, out_sof, out_eof and sample_idx stay stable until the transfer.
- States: IDLE, WAIT, READ, LATCH, HOLD, DONE.
- IDLE: frame_start with !rd_rst_busy causes the following on the next edge:
  - enter WAIT;
  - clear idx to 0 and the running sum to 0;
  - set running min to FF and running max to 00;
  - clear underrun_error and the timeout counter.
- WAIT:
  - !empty: go to READ; fifo_rd_en is registered high for exactly that cycle.
  - empty: increment the timeout counter. When it reaches TIMEOUT, set underrun_error=1 and go to IDLE. No stats_valid pulse and no frame_cnt increment.
- READ: fifo_rd_en=1 for exactly this cycle. Always go to LATCH.
- LATCH: on the edge leaving LATCH:
  - capture fifo_rd_data into out_data;
  - update running min/max;
  - add to the running sum, zero-extended to 16 bits (no overflow, since 256*255 < 65536);
  - set out_valid=1, out_sof=(idx==0), out_eof=(idx==FRAME_LEN-1), sample_idx=idx;
  - go to HOLD.
- HOLD, no transfer: stay in HOLD.
- HOLD, on transfer:
  - out_valid=0 and idx++.
  - If the sample was the last one: go to DONE.
  - Else if !empty: go to READ directly, giving 3 cycles per sample at full rate.
  - Else: go to WAIT and reset the timeout counter.
- DONE (one cycle):
  - load frame_min/max/sum from the running values;
  - pulse stats_valid for one cycle;
  - increment frame_cnt, wrapping FFFF->0000;
  - go to IDLE.
- fifo_rd_en is never asserted outside READ, never while empty=1, and never while rd_rst_busy=1.
- frame_start outside IDLE: ignored; no state, count or flag change.
- rd_rst_busy high in any state: next edge forces IDLE and clears out_valid, out_sof and out_eof.
  - frame_min/max/sum, frame_cnt and underrun_error are unchanged.
  - No stats_valid pulse.
- Simultaneous frame_start and rd_rst_busy: rd_rst_busy wins; the FSM stays in IDLE.
- Reset mid-frame: all state returns to reset values on the next edge; the partial frame is discarded.
- busy = (state != IDLE).

Test Plan:
- Nominal frame: FIFO preloaded with ramp 0..255, out_ready=1, frame_start pulse. Required response:
  - 256 fifo_rd_en pulses and 256 transfers, 3 cycles apart;
  - sof on idx 0, eof on idx 255;
  - stats_valid once with min=0, max=255, sum=32640;
  - frame_cnt=1 and busy low after DONE.
- Backpressure: out_ready toggling with a 1-on/3-off pattern on an all-0xA5 frame. Required response:
  - out_data stable while valid && !ready;
  - no extra reads;
  - sum=0xA500, min=max=0xA5.
- Underrun: only 10 samples in the FIFO, TIMEOUT=20. Required response:
  - 10 transfers;
  - underrun_error rises exactly 20 cycles after entering WAIT with empty=1;
  - FSM returns to IDLE, no stats_valid, frame_cnt unchanged;
  - the next frame_start clears the flag.
- rd_rst_busy asserted during sample 100. Required response:
  - IDLE on the next edge, out_valid=0;
  - frame outputs retain the previous frame's values;
  - a frame_start while rd_rst_busy=1 is ignored.
- frame_start repeated mid-frame at idx 50: ignored; the frame completes with 256 samples and frame_cnt increments once.
- rst_n low for 1 cycle at idx 128: all outputs return to 0 on the next edge and fifo_rd_en stays 0 until a new frame_start.
